// File: rtl/alu_result_sequencer_if.sv
// Bus between the ALU-side controller and the result sequencer.
// slave  : sequencer side (takes ALUout and commands, drives Result and status).
// master : controller or bench side (drives ALUout and commands, reads status).
// Signals:
//   ALUout  - combinational ALU result, sampled only on capture edges
//   Step    - single-capture request (idle only)
//   Start   - begin a repeat run of Count captures (idle only)
//   Count   - capture count, sampled with Start
//   Hold    - freeze an active run
//   Clear   - synchronous clear and abort
//   Result  - registered captured value
//   B_fb    - low half of Result, fed back to the ALU B operand
//   Zero    - Result == 0
//   Busy    - run in progress
//   Done    - one-cycle run-completion pulse
//   OpCount - saturating number of captures since reset or Clear
interface alu_result_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned OPC_W = 8
);
  logic [WIDTH-1:0]   ALUout;
  logic               Step;
  logic               Start;
  logic [CNT_W-1:0]   Count;
  logic               Hold;
  logic               Clear;
  logic [WIDTH-1:0]   Result;
  logic [WIDTH/2-1:0] B_fb;
  logic               Zero;
  logic               Busy;
  logic               Done;
  logic [OPC_W-1:0]   OpCount;

  modport slave (
    input  ALUout, Step, Start, Count, Hold, Clear,
    output Result, B_fb, Zero, Busy, Done, OpCount
  );

  modport master (
    output ALUout, Step, Start, Count, Hold, Clear,
    input  Result, B_fb, Zero, Busy, Done, OpCount
  );
endinterface

// File: rtl/alu_result_sequencer.sv
// Result register and accumulate-loop sequencer sitting behind the 4-bit ALU.
// Captures ALUout into Result, feeds Result's low half back as the ALU B operand,
// and either runs the loop for Count non-held cycles (Start) or captures once (Step).
// Ports:
//   Clock   - rising-edge clock
//   Reset_b - asynchronous active-low reset
//   bus     - alu_result_sequencer_if.slave (commands in, result and status out)
module alu_result_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned OPC_W = 8
) (
  input logic                    Clock,
  input logic                    Reset_b,
  alu_result_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] remaining_q;
  logic [OPC_W-1:0] opcount_q;
  logic             busy_q;
  logic             done_q;

  logic [OPC_W-1:0] opcount_inc;

  // Saturating increment used by every capture.
  assign opcount_inc = (opcount_q == '1) ? opcount_q : opcount_q + OPC_W'(1);

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q     <= StIdle;
      result_q    <= '0;
      remaining_q <= '0;
      opcount_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.Clear) begin
      // Abort without a Done pulse; all other commands dropped this cycle.
      state_q     <= StIdle;
      result_q    <= '0;
      remaining_q <= '0;
      opcount_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            // Start wins over Step; the run's first capture is on the next edge.
            if (bus.Count != '0) begin
              state_q     <= StRun;
              remaining_q <= bus.Count;
              busy_q      <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else if (bus.Step) begin
            result_q  <= bus.ALUout;
            opcount_q <= opcount_inc;
          end
        end
        StRun: begin
          if (!bus.Hold) begin
            result_q    <= bus.ALUout;
            opcount_q   <= opcount_inc;
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Result  = result_q;
  assign bus.B_fb    = result_q[WIDTH/2-1:0];
  assign bus.Zero    = (result_q == '0);
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.OpCount = opcount_q;

endmodule

// File: tb/tb_alu_result_sequencer.sv
// Bench for alu_result_sequencer: ALU modelled as ALUout = A + B_fb (zero-extended).
// A per-edge behavioural model tracks result, capture count, remaining run length and
// Busy/Done; every tick compares all outputs, plus directed checks for the test plan.
module tb_alu_result_sequencer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OPC_W = 8;
  localparam int unsigned HALF  = WIDTH / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [HALF-1:0] a = '0;

  int total = 0;
  int bad = 0;

  // Reference model state.
  int m_res = 0;
  int m_opc = 0;
  int m_left = 0;
  bit m_busy = 0;
  bit m_done = 0;

  always #5 clk = ~clk;

  alu_result_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .OPC_W(OPC_W)) bus ();

  assign bus.ALUout = {{HALF{1'b0}}, a} + {{HALF{1'b0}}, bus.B_fb};

  alu_result_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .OPC_W(OPC_W)) dut (
    .Clock   (clk),
    .Reset_b (rst_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_capture();
    m_res = (int'(a) + (m_res % (1 << HALF))) % (1 << WIDTH);
    m_opc = (m_opc < (1 << OPC_W) - 1) ? m_opc + 1 : m_opc;
  endtask

  task automatic model_reset();
    m_res = 0; m_opc = 0; m_left = 0; m_busy = 0; m_done = 0;
  endtask

  // Apply the behaviour rules for the edge about to happen, using current inputs.
  task automatic model_edge();
    if (bus.Clear) begin
      model_reset();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (!bus.Hold) begin
        model_capture();
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (bus.Start) begin
      if (bus.Count != 0) begin
        m_busy = 1;
        m_left = int'(bus.Count);
      end else begin
        m_done = 1;
      end
    end else if (bus.Step) begin
      model_capture();
    end
  endtask

  task automatic check_all();
    chk("result", 32'(bus.Result), 32'(m_res));
    chk("b_fb", 32'(bus.B_fb), 32'(m_res % (1 << HALF)));
    chk("zero", 32'(bus.Zero), 32'(m_res == 0));
    chk("busy", 32'(bus.Busy), 32'(m_busy));
    chk("done", 32'(bus.Done), 32'(m_done));
    chk("opcount", 32'(bus.OpCount), 32'(m_opc));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.Step = 0; bus.Start = 0; bus.Hold = 0; bus.Clear = 0; bus.Count = '0;
  endtask

  task automatic do_clear();
    idle_inputs();
    bus.Clear = 1;
    tick();
    bus.Clear = 0;
  endtask

  task automatic start_run(input int cnt);
    bus.Start = 1;
    bus.Count = CNT_W'(cnt);
    tick();
    bus.Start = 0;
    bus.Count = '0;
  endtask

  initial begin
    int busy_cycles;
    idle_inputs();
    #2;
    // Reset state while reset is asserted.
    chk("rst_result", 32'(bus.Result), 32'h0);
    chk("rst_zero", 32'(bus.Zero), 32'h1);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    chk("rst_opcount", 32'(bus.OpCount), 32'h0);
    @(negedge clk);
    rst_n = 1;

    // A=3, Count=4 -> 3, 6, 9, 12.
    a = 4'd3;
    start_run(4);
    chk("t1_busy_start", 32'(bus.Busy), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t1_seq", 32'(bus.Result), 32'(3 * i));
      chk("t1_busy", 32'(bus.Busy), 32'(i < 4));
    end
    chk("t1_done", 32'(bus.Done), 32'h1);
    chk("t1_final", 32'(bus.Result), 32'h0C);
    chk("t1_bfb", 32'(bus.B_fb), 32'hC);
    chk("t1_opc", 32'(bus.OpCount), 32'h4);
    chk("t1_zero", 32'(bus.Zero), 32'h0);
    tick();
    chk("t1_done_once", 32'(bus.Done), 32'h0);

    // A=5 from zero -> 5, 10, 15, 0x14.
    do_clear();
    a = 4'd5;
    start_run(4);
    repeat (4) tick();
    chk("t2_final", 32'(bus.Result), 32'h14);
    chk("t2_bfb", 32'(bus.B_fb), 32'h4);
    chk("t2_done", 32'(bus.Done), 32'h1);
    tick();
    chk("t2_done_once", 32'(bus.Done), 32'h0);

    // Hold for two cycles after the second capture.
    do_clear();
    a = 4'd3;
    start_run(4);
    busy_cycles = 1;
    repeat (2) tick();
    busy_cycles += 2;
    bus.Hold = 1;
    repeat (2) begin
      tick();
      chk("t3_hold_result", 32'(bus.Result), 32'h6);
      if (bus.Busy) busy_cycles++;
    end
    bus.Hold = 0;
    for (int i = 0; i < 20 && bus.Busy; i++) begin
      tick();
      if (bus.Busy) busy_cycles++;
    end
    chk("t3_busy_cycles", 32'(busy_cycles), 32'd6);
    chk("t3_final", 32'(bus.Result), 32'h0C);
    chk("t3_done", 32'(bus.Done), 32'h1);
    tick();

    // Count=0: no capture, Done next cycle.
    start_run(0);
    chk("t4_done", 32'(bus.Done), 32'h1);
    chk("t4_result", 32'(bus.Result), 32'h0C);
    chk("t4_opc", 32'(bus.OpCount), 32'h4);
    tick();
    chk("t4_done_off", 32'(bus.Done), 32'h0);

    // Step three times from zero with A=2.
    do_clear();
    a = 4'd2;
    repeat (3) begin
      bus.Step = 1;
      tick();
      chk("t5_done", 32'(bus.Done), 32'h0);
      bus.Step = 0;
      tick();
    end
    chk("t5_result", 32'(bus.Result), 32'h6);
    chk("t5_opc", 32'(bus.OpCount), 32'h3);
    // Step held high during a run adds nothing: 6 -> 7 -> 8.
    a = 4'd1;
    start_run(2);
    bus.Step = 1;
    repeat (3) tick();
    bus.Step = 0;
    chk("t5_run_step", 32'(bus.OpCount), 32'h5);
    chk("t5_run_result", 32'(bus.Result), 32'h8);
    tick();

    // Asynchronous reset mid-run.
    a = 4'd3;
    start_run(4);
    repeat (2) tick();
    #2;
    rst_n = 0;
    #1;
    chk("t6_result", 32'(bus.Result), 32'h0);
    chk("t6_busy", 32'(bus.Busy), 32'h0);
    chk("t6_zero", 32'(bus.Zero), 32'h1);
    model_reset();
    #1;
    rst_n = 1;
    tick();

    // Clear mid-run: no Done pulse.
    start_run(4);
    repeat (2) tick();
    bus.Clear = 1;
    tick();
    bus.Clear = 0;
    chk("t7_result", 32'(bus.Result), 32'h0);
    chk("t7_busy", 32'(bus.Busy), 32'h0);
    repeat (3) begin
      tick();
      chk("t7_no_done", 32'(bus.Done), 32'h0);
    end

    // OpCount saturation.
    do_clear();
    bus.Step = 1;
    repeat (260) tick();
    bus.Step = 0;
    chk("t8_sat", 32'(bus.OpCount), 32'hFF);

    // Randomized traffic against the model.
    do_clear();
    repeat (400) begin
      a = HALF'($urandom_range(0, (1 << HALF) - 1));
      bus.Step  = ($urandom_range(0, 2) == 0);
      bus.Start = ($urandom_range(0, 5) == 0);
      bus.Count = CNT_W'($urandom_range(0, 6));
      bus.Hold  = ($urandom_range(0, 3) == 0);
      bus.Clear = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
